// File: rtl/sys_arr_pkg.sv
// Shared types and default sizing for the systolic array sequencer.
package sys_arr_pkg;

  localparam int unsigned ARR_SIZE_DEF   = 2;
  localparam int unsigned ADDR_WIDTH_DEF = 8;
  localparam int unsigned CNT_WIDTH_DEF  = 8;
  localparam int unsigned OUT_LAT_DEF    = 3;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LOAD_W  = 3'd1,
    COMPUTE = 3'd2,
    DRAIN   = 3'd3,
    DONE    = 3'd4
  } state_t;

endpackage

// File: rtl/sys_arr_ctrl_if.sv
// Host command interface: job parameters and start in, busy/done status out.
interface sys_arr_ctrl_if
  import sys_arr_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int unsigned CNT_WIDTH  = CNT_WIDTH_DEF
);
  logic                  start;
  logic [CNT_WIDTH-1:0]  num_rows;
  logic [ADDR_WIDTH-1:0] weight_base;
  logic [ADDR_WIDTH-1:0] data_base;
  logic [ADDR_WIDTH-1:0] out_base;
  logic                  busy;
  logic                  done;

  modport master (
    output start, num_rows, weight_base, data_base, out_base,
    input  busy, done
  );

  modport slave (
    input  start, num_rows, weight_base, data_base, out_base,
    output busy, done
  );
endinterface

// File: rtl/ctrl_delay_line.sv
// 1-bit shift register; pending flags a 1 that has yet to reach q.
module ctrl_delay_line #(
  parameter int unsigned DEPTH = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q,
  output logic pending
);
  logic [DEPTH-1:0] sr;

  generate
    if (DEPTH == 1) begin : g_one
      always_ff @(posedge clk) begin
        if (reset) sr <= '0;
        else       sr <= d;
      end
      assign pending = d;
    end else begin : g_multi
      always_ff @(posedge clk) begin
        if (reset) sr <= '0;
        else       sr <= {sr[DEPTH-2:0], d};
      end
      // The output stage is excluded: it is the final cycle of its pulse.
      assign pending = d | (|sr[DEPTH-2:0]);
    end
  endgenerate

  assign q = sr[DEPTH-1];
endmodule

// File: rtl/sys_arr_ctrl.sv
// Job sequencer for the systolic MAC array: weight load, data streaming,
// skewed row enables and per-column output write strobes/addresses.
module sys_arr_ctrl
  import sys_arr_pkg::*;
#(
  parameter int unsigned ARR_SIZE   = ARR_SIZE_DEF,
  parameter int unsigned ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int unsigned CNT_WIDTH  = CNT_WIDTH_DEF,
  parameter int unsigned OUT_LAT    = OUT_LAT_DEF
) (
  input  logic                         clk,
  input  logic                         reset,
  sys_arr_ctrl_if.slave                host,
  output logic                         wmem_rd_en,
  output logic [ADDR_WIDTH-1:0]        wmem_addr,
  output logic [ARR_SIZE-1:0]          wwrite,
  output logic                         dmem_rd_en,
  output logic [ADDR_WIDTH-1:0]        dmem_addr,
  output logic                         active,
  output logic [ARR_SIZE-1:0]          row_en,
  output logic [ARR_SIZE-1:0]          out_wr_en,
  output logic [ARR_SIZE*ADDR_WIDTH-1:0] out_addr
);

  state_t                state;
  logic [CNT_WIDTH-1:0]  k_cnt;
  logic [CNT_WIDTH-1:0]  i_cnt;
  logic [CNT_WIDTH-1:0]  n_q;
  logic [ADDR_WIDTH-1:0] wbase_q;
  logic [ADDR_WIDTH-1:0] dbase_q;
  logic                  accept;
  logic                  ww_q;
  logic                  ww_pend;
  logic                  act_pend;
  logic [ARR_SIZE-1:0]   row_pend;
  logic [ARR_SIZE-1:0]   out_pend;
  logic                  drain_empty;

  assign accept      = (state == IDLE) && host.start;
  assign drain_empty = !(ww_pend || act_pend || (|row_pend) || (|out_pend));

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      k_cnt   <= '0;
      i_cnt   <= '0;
      n_q     <= '0;
      wbase_q <= '0;
      dbase_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (host.start) begin
            state   <= LOAD_W;
            n_q     <= host.num_rows;
            wbase_q <= host.weight_base;
            dbase_q <= host.data_base;
            k_cnt   <= '0;
            i_cnt   <= '0;
          end
        end
        LOAD_W: begin
          if (k_cnt == CNT_WIDTH'(ARR_SIZE - 1)) begin
            k_cnt <= '0;
            state <= (n_q == '0) ? DRAIN : COMPUTE;
          end else begin
            k_cnt <= k_cnt + 1'b1;
          end
        end
        COMPUTE: begin
          // Terminal compare against n_q-1 keeps N = 2^CNT_WIDTH-1 from overflowing.
          if (i_cnt == n_q - 1'b1) begin
            i_cnt <= '0;
            state <= DRAIN;
          end else begin
            i_cnt <= i_cnt + 1'b1;
          end
        end
        DRAIN: begin
          if (drain_empty) state <= DONE;
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign host.busy  = (state != IDLE);
  assign host.done  = (state == DONE);
  assign wmem_rd_en = (state == LOAD_W);
  assign dmem_rd_en = (state == COMPUTE);
  assign wmem_addr  = wbase_q + ADDR_WIDTH'(k_cnt);
  assign dmem_addr  = dbase_q + ADDR_WIDTH'(i_cnt);

  ctrl_delay_line #(.DEPTH(1)) u_ww_dl (
    .clk(clk), .reset(reset), .d(wmem_rd_en), .q(ww_q), .pending(ww_pend)
  );
  assign wwrite = {ARR_SIZE{ww_q}};

  ctrl_delay_line #(.DEPTH(1)) u_act_dl (
    .clk(clk), .reset(reset), .d(dmem_rd_en), .q(active), .pending(act_pend)
  );

  assign row_en[0]   = active;
  assign row_pend[0] = 1'b0;

  generate
    for (genvar r = 1; r < ARR_SIZE; r++) begin : g_row
      ctrl_delay_line #(.DEPTH(r)) u_row_dl (
        .clk(clk), .reset(reset), .d(active), .q(row_en[r]), .pending(row_pend[r])
      );
    end

    for (genvar c = 0; c < ARR_SIZE; c++) begin : g_col
      logic [ADDR_WIDTH-1:0] addr_q;

      ctrl_delay_line #(.DEPTH(OUT_LAT + c)) u_out_dl (
        .clk(clk), .reset(reset), .d(active), .q(out_wr_en[c]), .pending(out_pend[c])
      );

      always_ff @(posedge clk) begin
        if (reset)             addr_q <= '0;
        else if (accept)       addr_q <= host.out_base;
        else if (out_wr_en[c]) addr_q <= addr_q + 1'b1;
      end

      assign out_addr[c*ADDR_WIDTH +: ADDR_WIDTH] = addr_q;
    end
  endgenerate

endmodule

// File: doc/sys_arr_ctrl.md
Name: sys_arr_ctrl

Overview:
Sequencer for the ARR_SIZE x ARR_SIZE systolic MAC array.
- One job per start pulse: load one weight tile into the array, stream num_rows input vectors through it, and generate write strobes and addresses so each column's results are captured into an output buffer.
- Sits between the host/command interface and the array plus its weight, data and output SRAMs.
- Drives the array's wwrite/active/row-enable controls only; it carries no data.

Parameters:
ARR_SIZE, 2, array dimension (rows = columns).
ADDR_WIDTH, 8, SRAM address width; all address arithmetic is modulo 2^ADDR_WIDTH.
CNT_WIDTH, 8, width of the num_rows field and of the internal counters.
OUT_LAT, 3, cycles from active to column-0 result valid at the array bottom.

Ports:
clk  in  1  clock; all logic on the rising edge.
reset  in  1  synchronous, active-high reset.
start  in  1  job request; sampled only in IDLE.
num_rows  in  CNT_WIDTH  input vectors per job; latched at start.
weight_base  in  ADDR_WIDTH  first weight SRAM row; latched at start.
data_base  in  ADDR_WIDTH  first data SRAM row; latched at start.
out_base  in  ADDR_WIDTH  first output SRAM row, per column; latched at start.
busy  out  1  high from the cycle after start is accepted through the DONE cycle.
done  out  1  one-cycle completion pulse.
wmem_rd_en  out  1  weight SRAM read enable.
wmem_addr  out  ADDR_WIDTH  weight SRAM read address.
wwrite  out  ARR_SIZE  per-column weight write enable into the array top row.
dmem_rd_en  out  1  data SRAM read enable.
dmem_addr  out  ADDR_WIDTH  data SRAM read address.
active  out  1  array active input for the top-left PE.
row_en  out  ARR_SIZE  per-row data valid (skewed); row_en[0] equals active.
out_wr_en  out  ARR_SIZE  per-column output SRAM write enable.
out_addr  out  ARR_SIZE*ADDR_WIDTH  per-column write address; column c occupies bits [c*ADDR_WIDTH +: ADDR_WIDTH].

Behaviour:
- Reset: all outputs 0, FSM to IDLE, all counters and delay lines cleared. Reset mid-job aborts the job immediately with no done pulse.
- Timing convention: t0 is the cycle in which start is sampled high in IDLE.
- Inputs num_rows and the three base addresses are registered at t0 and ignored afterwards. start while busy is ignored.
- IDLE: all strobes 0. A sampled start moves the FSM to LOAD_W.
- LOAD_W (ARR_SIZE cycles, t0+1 .. t0+ARR_SIZE):
  - wmem_rd_en=1, wmem_addr = weight_base + k, k = 0..ARR_SIZE-1.
  - Weight SRAM read latency is 1 cycle, so wwrite = all ones exactly at t0+2 .. t0+ARR_SIZE+1 (wmem_rd_en delayed by 1).
- COMPUTE (num_rows cycles, starting t0+ARR_SIZE+1):
  - dmem_rd_en=1, dmem_addr = data_base + i.
  - active = dmem_rd_en delayed by 1; its first cycle is always after the last wwrite cycle.
  - num_rows==0: COMPUTE is skipped and the FSM goes from LOAD_W straight to DRAIN. This performs a weight-only load with no active, no out_wr_en, and done at t0+ARR_SIZE+2.
- row_en[r] = active delayed by r cycles (input skew).
- out_wr_en[c] = active delayed by OUT_LAT + c cycles.
- Each column's address counter starts at out_base and increments after every out_wr_en[c] write.
- DRAIN: waits until every delay line is empty and every out_wr_en is 0, then moves to DONE.
- DONE: one cycle, done=1, busy=1, then IDLE. A start in the DONE cycle is ignored; start is accepted again from the next IDLE cycle.
- Total job length for num_rows=N>0: done at t0 + ARR_SIZE + N + OUT_LAT + ARR_SIZE + 1.
- num_rows counter is CNT_WIDTH wide; N = 2^CNT_WIDTH-1 must complete with no overflow. Address counters wrap silently.

Decomposition:
- Shared package sys_arr_pkg: FSM state enum (IDLE, LOAD_W, COMPUTE, DRAIN, DONE) and default ARR_SIZE/ADDR_WIDTH/CNT_WIDTH constants.
- One sub-module: ctrl_delay_line (parameterised DEPTH, 1-bit shift register with reset). It is instantiated for the wwrite delay, the row_en skew and the out_wr_en delays.

Test Plan:
- ARR_SIZE=2, OUT_LAT=3, start at cycle 0, N=3, bases w=0x10, d=0x20, o=0x40:
  - wmem_rd_en at cycles 1-2, addresses 0x10, 0x11; wwrite=2'b11 at cycles 2-3.
  - dmem_rd_en at cycles 3-5, addresses 0x20-0x22; active at 4-6; row_en[1] at 5-7.
  - out_wr_en[0] at 7-9, out_wr_en[1] at 8-10, each column's addresses 0x40-0x42; done at cycle 11; busy high at 1-11.
- num_rows=0: wwrite pulses as above; active and out_wr_en never assert; done at cycle 4.
- start held high continuously: a second job is accepted only in the first IDLE cycle after done. No overlap of wwrite with active.
- Reset asserted at cycle 5 of the first scenario: every output is 0 from cycle 6, no done pulse. A new start afterwards runs a clean job with the same timing.
- data_base=0xFF, N=3: dmem_addr sequence 0xFF, 0x00, 0x01 (wrap).
- num_rows=255: exactly 255 out_wr_en pulses per column, and done at t0+2+255+3+2+1 = t0+263.
